// File: rtl/fifo_word_packer_pkg.sv
// Shared types and default sizing for the FIFO word packer.
package mannix_pack_pkg;

   typedef enum logic {PK_FILL, PK_HOLD} pack_state_e;

   localparam int PACK_DATA_W = 8;
   localparam int PACK_N_DEF  = 4;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops show-ahead FIFO entries and packs PACK_N of them into one wide word.
// A flush closes a partial word early with a keep mask and out_last set.
module fifo_word_packer
   import mannix_pack_pkg::*;
#(
   parameter int DATA_W = PACK_DATA_W,
   parameter int PACK_N = PACK_N_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fifo_empty,
   input  logic [DATA_W-1:0]          fifo_data,
   output logic                       fifo_rd_en,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PACK_N*DATA_W-1:0]   out_data,
   output logic [PACK_N-1:0]          out_keep,
   output logic                       out_last,
   output logic                       busy
);

   localparam int IDX_W = $clog2(PACK_N);

   // Output handshake: a word transfers in any cycle with out_valid && out_ready.
   // out_valid is a register and never looks at out_ready; once raised, data,
   // keep and last hold until the transfer.

   pack_state_e             state;
   logic [IDX_W-1:0]        idx;
   logic [DATA_W-1:0]       lane_q [PACK_N];
   logic                    pop;
   logic                    accept;
   logic                    last_lane;

   assign pop        = (state == PK_FILL) && !fifo_empty && !rst;
   assign fifo_rd_en = pop;
   assign accept     = out_valid && out_ready;
   assign last_lane  = (idx == IDX_W'(PACK_N - 1));
   assign busy       = out_valid || (idx != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PK_FILL;
         idx       <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            PK_FILL: begin
               if (pop) begin
                  out_keep[idx] <= 1'b1;
                  if (last_lane || flush) begin
                     state     <= PK_HOLD;
                     out_valid <= 1'b1;
                     out_last  <= flush;
                     idx       <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else if (flush && (idx != '0)) begin
                  state     <= PK_HOLD;
                  out_valid <= 1'b1;
                  out_last  <= 1'b1;
                  idx       <= '0;
               end
            end
            PK_HOLD: begin
               if (accept) begin
                  state     <= PK_FILL;
                  out_valid <= 1'b0;
                  out_keep  <= '0;
                  out_last  <= 1'b0;
               end
            end
            default: state <= PK_FILL;
         endcase
      end
   end

   // Lanes are zeroed on accept so unused lanes of the next word read as 0.
   for (genvar lane = 0; lane < PACK_N; lane++) begin : g_lane
      logic lane_we;
      assign lane_we = pop && (idx == IDX_W'(lane));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lane_q[lane] <= '0;
         end else if (accept) begin
            lane_q[lane] <= '0;
         end else if (lane_we) begin
            lane_q[lane] <= fifo_data;
         end
      end

      assign out_data[lane*DATA_W +: DATA_W] = lane_q[lane];
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized bench for fifo_word_packer with a byte-list reference model.
module tb_fifo_word_packer;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic           fifo_empty;
   logic [W-1:0]   fifo_data;
   logic           fifo_rd_en;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_keep;
   logic           out_last;
   logic           busy;

   fifo_word_packer #(.DATA_W(W), .PACK_N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .out_last   (out_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model and gap injection
   logic [W-1:0]   fq [$];
   logic           gap;
   int             pops;

   // Reference model: bytes collected so far, and the word presented (if any)
   logic [W-1:0]   cur [$];
   logic           held;
   logic [N*W-1:0] hold_data;
   logic [N-1:0]   hold_keep;
   logic           hold_last;

   // Scoreboard of words actually transferred
   logic [N*W-1:0] got_data [$];
   logic [N-1:0]   got_keep [$];
   logic           got_last [$];

   int checks;
   int errors;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic update_if();
      fifo_empty = (fq.size() == 0) || gap;
      fifo_data  = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic push(input logic [W-1:0] b);
      fq.push_back(b);
      update_if();
   endtask

   function automatic logic [N*W-1:0] pack_bytes();
      logic [N*W-1:0] w;
      w = '0;
      for (int i = 0; i < cur.size(); i++) w[i*W +: W] = cur[i];
      return w;
   endfunction

   function automatic logic [N-1:0] mask_of(input int n);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      held = 1'b0;
      cur.delete();
      hold_data = '0;
      hold_keep = '0;
      hold_last = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid"}, out_valid, held);
      check({tag, "_data"},  out_data,  held ? hold_data : pack_bytes());
      check({tag, "_keep"},  out_keep,  held ? hold_keep : mask_of(cur.size()));
      check({tag, "_last"},  out_last,  held ? hold_last : 1'b0);
      check({tag, "_busy"},  busy,      held || (cur.size() != 0));
   endtask

   task automatic cycle(input logic fl, input logic rdy, input logic gp);
      logic       pop_now;
      logic [W-1:0] head;
      flush     = fl;
      out_ready = rdy;
      gap       = gp;
      update_if();
      #1;
      check("rd_en", fifo_rd_en, !held && !fifo_empty);
      pop_now = fifo_rd_en;
      head    = fifo_data;
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_keep.push_back(out_keep);
         got_last.push_back(out_last);
      end
      @(posedge clk);
      #1;
      if (pop_now) begin
         void'(fq.pop_front());
         pops++;
      end
      if (held) begin
         if (rdy) begin
            held = 1'b0;
            hold_data = '0;
            hold_keep = '0;
            hold_last = 1'b0;
         end
      end else begin
         if (pop_now) cur.push_back(head);
         if ((cur.size() == N) || (fl && (cur.size() != 0))) begin
            held      = 1'b1;
            hold_data = pack_bytes();
            hold_keep = mask_of(cur.size());
            hold_last = fl;
            cur.delete();
         end
      end
      flush = 1'b0;
      gap   = 1'b0;
      update_if();
      check_outputs("cyc");
   endtask

   task automatic drain(input int budget);
      logic idle;
      for (int i = 0; i < budget; i++) begin
         if (fq.size() == 0 && !held && cur.size() == 0) break;
         cycle((fq.size() == 0) && !held && (cur.size() != 0), 1'b1, 1'b0);
      end
      idle = (fq.size() == 0) && !held && (cur.size() == 0);
      check("drain_idle", idle, 1'b1);
   endtask

   task automatic expect_word(input string tag, input logic [N*W-1:0] d,
                              input logic [N-1:0] k, input logic l);
      check({tag, "_present"}, got_data.size() != 0, 1'b1);
      if (got_data.size() != 0) begin
         check({tag, "_data"}, got_data.pop_front(), d);
         check({tag, "_keep"}, got_keep.pop_front(), k);
         check({tag, "_last"}, got_last.pop_front(), l);
      end
   endtask

   initial begin
      int fq_before;
      int n_pushed;
      checks = 0;
      errors = 0;
      pops   = 0;
      rst    = 1'b1;
      flush  = 1'b0;
      out_ready = 1'b0;
      gap    = 1'b0;
      model_reset();
      update_if();
      #3;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data",  out_data,  32'h0);
      check("rst_keep",  out_keep,  4'h0);
      check("rst_last",  out_last,  1'b0);
      check("rst_busy",  busy,      1'b0);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      push(8'hEE);
      #1;
      check("rst_rd_en_nonempty", fifo_rd_en, 1'b0);
      void'(fq.pop_front());
      update_if();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic pack
      pops = 0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      drain(20);
      check("basic_pops", pops, 4);
      expect_word("basic", 32'h44332211, 4'b1111, 1'b0);

      // Backpressure with extra entries waiting in the FIFO
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h77); push(8'h88);
      for (int i = 0; i < 10 && !out_valid; i++) cycle(1'b0, 1'b0, 1'b0);
      check("bp_valid_rose", out_valid, 1'b1);
      fq_before = fq.size();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         check("bp_held_data", out_data, 32'h44332211);
         check("bp_fifo_cnt", fq.size(), fq_before);
      end
      cycle(1'b0, 1'b1, 1'b0);
      check("bp_accepted", got_data.size(), 1);
      drain(20);
      expect_word("bp", 32'h44332211, 4'b1111, 1'b0);
      expect_word("bp_tail", 32'h00008877, 4'b0011, 1'b1);

      // Partial flush with the FIFO empty
      push(8'hA1); push(8'hB2);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      expect_word("pflush", 32'h0000B2A1, 4'b0011, 1'b1);

      // Flush coincident with the pop of the third entry
      push(8'h01); push(8'h02); push(8'h03);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      expect_word("cflush", 32'h00030201, 4'b0111, 1'b1);

      // Flush coincident with the pop that fills the last lane
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      expect_word("fullflush", 32'hC4C3C2C1, 4'b1111, 1'b1);

      // Flush with nothing collected emits nothing
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check("empty_flush_valid", out_valid, 1'b0);
      check("empty_flush_words", got_data.size(), 0);

      // Streaming with random empty gaps and random ready
      for (int i = 0; i < 12; i++) push(8'(i));
      for (int i = 0; i < 300 && got_data.size() < 3; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      expect_word("stream0", 32'h03020100, 4'b1111, 1'b0);
      expect_word("stream1", 32'h07060504, 4'b1111, 1'b0);
      expect_word("stream2", 32'h0B0A0908, 4'b1111, 1'b0);
      drain(20);

      // Reset mid-word
      push(8'h55); push(8'h66);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check("pre_rst_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_keep",  out_keep,  4'h0);
      check("mid_rst_data",  out_data,  32'h0);
      check("mid_rst_busy",  busy,      1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      check_outputs("post_rst");
      push(8'h10); push(8'h20); push(8'h30); push(8'h40);
      drain(20);
      expect_word("post_rst", 32'h40302010, 4'b1111, 1'b0);

      // Randomized soak: random pushes, gaps, flushes and backpressure
      got_data.delete(); got_keep.delete(); got_last.delete();
      n_pushed = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) != 0 && fq.size() < 16) begin
            push(8'($urandom_range(0, 255)));
            n_pushed++;
         end
         cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0));
      end
      drain(200);
      check("soak_some_words", got_data.size() > 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the byte FIFO. It pops FIFO entries and packs PACK_N consecutive entries into one wide word. The word is presented on a valid/ready output port to the accelerator datapath. A flush input closes a partial word early, marking the valid lanes with a keep mask and setting last.

Parameters:
DATA_W, 8, width of one FIFO entry (matches the FIFO width parameter)
PACK_N, 4, entries packed per output word; must be >= 2
IDX_W, $clog2(PACK_N), lane index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
fifo_empty  in  1  FIFO empty indication
fifo_data  in  DATA_W  FIFO head entry (show-ahead, valid whenever fifo_empty=0)
fifo_rd_en  out  1  pop strobe to FIFO read enable
flush  in  1  single-cycle request to close the current partial word
out_valid  out  1  packed word available
out_ready  in  1  sink accepts word
out_data  out  PACK_N*DATA_W  packed word; lane 0 = first popped entry, at bits [DATA_W-1:0]
out_keep  out  PACK_N  per-lane valid mask
out_last  out  1  word was closed by flush
busy  out  1  partial word held (idx!=0) or out_valid=1

Behaviour:
- Reset (asynchronous assert, released synchronously to clk): state=PK_FILL, idx=0, out_data=0, out_keep=0, out_last=0, out_valid=0, flush request not pending. fifo_rd_en is 0 while rst=1.
- States: PK_FILL (collecting entries), PK_HOLD (word presented).
- PK_FILL:
  - fifo_rd_en = !fifo_empty (combinational). A pop occurs in any cycle where fifo_rd_en=1.
  - On a pop, fifo_data is written into lane idx, keep[idx] is set, and idx increments.
  - Pop with idx==PACK_N-1: next cycle state=PK_HOLD, out_valid=1, out_last=0, idx wraps to 0.
  - flush=1 with idx>0 and no pop: next cycle PK_HOLD, out_last=1, keep covers lanes 0..idx-1.
  - flush=1 in the same cycle as a pop: the popped entry is included, then the word closes, with out_last=1 and keep covering lanes 0..idx. This applies even if that pop fills lane PACK_N-1.
  - flush=1 with idx==0 and no pop: no-op; no empty word is emitted.
  - flush is not stored; it is only sampled in PK_FILL.
- PK_HOLD:
  - fifo_rd_en=0.
  - out_data, out_keep and out_last are stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: next cycle state=PK_FILL, out_valid=0, out_keep=0, out_last=0, all lanes cleared to 0.
- Unused lanes (keep=0) always read as 0.
- Latency: the last pop of a word at cycle t gives out_valid=1 at t+1.
- Throughput: one bubble per word; with a never-empty FIFO and out_ready=1, one full word every PACK_N+1 cycles.
- The packer never pops while fifo_empty=1 (no FIFO underflow). FIFO overflow is the producer's responsibility.
- out_valid does not depend combinationally on out_ready. out_ready=1 with out_valid=0 has no effect.
- Reset mid-operation: the partial or held word is discarded and all outputs return to reset values. FIFO contents are untouched; the FIFO has its own reset.

Decomposition:
- Package mannix_pack_pkg holds:
  - typedef enum logic {PK_FILL, PK_HOLD} pack_state_e
  - default constants PACK_DATA_W=8 and PACK_N_DEF=4
- Single module, no sub-module. Lane registers are a generate loop over PACK_N with a per-lane write enable (pop && idx==lane), in one always_ff block with async reset.

Test Plan:
1. Basic pack: push 0x11,0x22,0x33,0x44 into the FIFO, out_ready=1 -> one word, out_data=0x44332211, out_keep=4'b1111, out_last=0, out_valid high 1 cycle; 4 pops seen.
2. Backpressure: same stimulus with out_ready=0 for 5 cycles after out_valid rises -> out_data held at 0x44332211, fifo_rd_en=0 throughout PK_HOLD, FIFO cnt unchanged; accepted on the first out_ready=1.
3. Partial flush: push 0xA1,0xB2, pulse flush while FIFO empty -> out_data=0x0000B2A1, out_keep=4'b0011, out_last=1.
4. Flush coincident with pop: push 0x01,0x02,0x03, flush in the cycle 0x03 is popped -> out_data=0x00030201, out_keep=4'b0111, out_last=1. Flush with idx==0 and FIFO empty -> out_valid stays 0.
5. Streaming/empty gaps: 12 entries 0x00..0x0B with random FIFO empty gaps and random out_ready -> words 0x03020100, 0x07060504, 0x0B0A0908 in order; no pop while fifo_empty=1.
6. Reset mid-word: pop 0x55,0x66, assert rst asynchronously mid-cycle -> out_valid/out_keep/out_data immediately 0 and busy=0. After release, push 0x10,0x20,0x30,0x40 -> 0x40302010 (no stale lanes).
